// File: rtl/pudding_pkg.sv
// pudding_pkg: shared constants, chain strobe positions and loader state type
package pudding_pkg;
    localparam int FRAME_BITS  = 128;
    localparam int FRAME_BYTES = FRAME_BITS / 8;
    localparam int UI_DATUM    = 0;
    localparam int UI_SHIFT    = 1;
    localparam int UI_TRANSFER = 2;
    localparam int UI_DIR      = 3;
    localparam int UI_STATEEN  = 4;
    typedef enum logic [3:0] {
        IDLE, WR_FETCH, WR_HI, WR_LO, WR_COMMIT, RD_XFER, RD_LO, RD_HI, RD_WAIT, DONE
    } state_t;
endpackage

// File: rtl/pudding_byte_sr.sv
// pudding_byte_sr: 8-bit right shifter (LSB out, new bit in at MSB) with bit counter
module pudding_byte_sr (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_data,
    input  logic       i_shift,
    input  logic       i_bit,
    output logic       o_bit,
    output logic [7:0] o_data,
    output logic [2:0] o_cnt
);
    logic [7:0] r_sr;
    logic [2:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sr  <= '0;
            r_cnt <= '0;
        end else if (i_load) begin
            r_sr  <= i_data;
            r_cnt <= '0;
        end else if (i_shift) begin
            r_sr  <= {i_bit, r_sr[7:1]};
            r_cnt <= r_cnt + 3'd1;
        end
    end
    assign o_bit  = r_sr[0];
    assign o_data = r_sr;
    assign o_cnt  = r_cnt;
endmodule

// File: rtl/pudding_cfg_loader.sv
// pudding_cfg_loader: byte-stream loader/reader for the pudding 128-bit config chain
module pudding_cfg_loader
    import pudding_pkg::*;
#(
    parameter int FRAME_BYTES = pudding_pkg::FRAME_BYTES
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start_wr,
    input  logic       i_start_rd,
    input  logic [7:0] i_in_data,
    input  logic       i_in_valid,
    output logic       o_in_ready,
    output logic [7:0] o_rd_data,
    output logic       o_rd_valid,
    input  logic       i_rd_ready,
    input  logic       i_chain_msb,
    output logic       o_chain_datum,
    output logic       o_chain_shift,
    output logic       o_chain_transfer,
    output logic       o_chain_dir,
    output logic       o_chain_stateen,
    output logic       o_busy,
    output logic       o_done
);
    localparam int BW = FRAME_BYTES > 1 ? $clog2(FRAME_BYTES) : 1;
    state_t        r_state, w_next;
    logic [BW-1:0] r_byte;
    logic          r_bit, r_all, r_stateen, r_rd_valid;
    logic [7:0]    r_rd_data, w_sr_data;
    logic [2:0]    w_cnt;
    logic [4:0]    w_ui;
    logic          w_sr_bit, w_free, w_last_byte, w_load_rd;
    assign w_free      = !r_rd_valid || i_rd_ready;
    assign w_last_byte = r_byte == BW'(FRAME_BYTES - 1);
    // a gathered byte is pending either right after its 8th capture or while parked in RD_WAIT
    assign w_load_rd   = w_free && ((r_state == RD_HI && w_cnt == 3'd0) || (r_state == RD_WAIT && !r_all));
    pudding_byte_sr u_sr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_load  ((r_state == WR_FETCH && i_in_valid) || r_state == RD_XFER),
        .i_data  (i_in_data),
        .i_shift (r_state == WR_LO || r_state == RD_LO),
        .i_bit   (i_chain_msb),
        .o_bit   (w_sr_bit),
        .o_data  (w_sr_data),
        .o_cnt   (w_cnt)
    );
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = i_start_wr ? WR_FETCH : i_start_rd ? RD_XFER : IDLE;
            WR_FETCH:  w_next = i_in_valid ? WR_HI : WR_FETCH;
            WR_HI:     w_next = WR_LO;
            WR_LO:     w_next = w_cnt != 3'd7 ? WR_HI : w_last_byte ? WR_COMMIT : WR_FETCH;
            WR_COMMIT: w_next = DONE;
            RD_XFER:   w_next = RD_LO;
            RD_LO:     w_next = RD_HI;
            RD_HI:     w_next = (w_cnt != 3'd0 || (w_free && !w_last_byte)) ? RD_LO : RD_WAIT;
            RD_WAIT:   w_next = r_all ? (i_rd_ready ? DONE : RD_WAIT) :
                                (w_free && !w_last_byte) ? RD_LO : RD_WAIT;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end
    always_comb begin
        w_ui              = '0;
        w_ui[UI_DATUM]    = (r_state == WR_HI || r_state == WR_LO) ? w_sr_bit : r_state == RD_HI ? r_bit : 1'b0;
        w_ui[UI_SHIFT]    = r_state == WR_HI || r_state == RD_HI;
        w_ui[UI_TRANSFER] = r_state == WR_COMMIT || r_state == RD_XFER;
        w_ui[UI_DIR]      = r_state == WR_COMMIT;
        w_ui[UI_STATEEN]  = r_stateen;
    end
    assign o_chain_datum    = w_ui[UI_DATUM];
    assign o_chain_shift    = w_ui[UI_SHIFT];
    assign o_chain_transfer = w_ui[UI_TRANSFER];
    assign o_chain_dir      = w_ui[UI_DIR];
    assign o_chain_stateen  = w_ui[UI_STATEEN];
    assign o_in_ready       = r_state == WR_FETCH;
    assign o_busy           = r_state != IDLE;
    assign o_done           = r_state == DONE;
    assign o_rd_data        = r_rd_data;
    assign o_rd_valid       = r_rd_valid;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_byte     <= '0;
            r_bit      <= 1'b0;
            r_all      <= 1'b0;
            r_stateen  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_stateen <= 1'b1;
            if (r_state == RD_LO) r_bit <= i_chain_msb;
            if ((r_state == WR_LO && w_cnt == 3'd7) || w_load_rd) r_byte <= r_byte + BW'(1);
            if (w_load_rd && w_last_byte) r_all <= 1'b1;
            else if (r_state == DONE) r_all <= 1'b0;
            if (w_load_rd) begin
                r_rd_data  <= w_sr_data;
                r_rd_valid <= 1'b1;
            end else if (r_rd_valid && i_rd_ready) r_rd_valid <= 1'b0;
        end
    end
endmodule

// File: doc/pudding_cfg_loader.md
PUDDING_CFG_LOADER -- requirements
Module: pudding_cfg_loader

Interface
REQ-001 Parameter FRAME_BYTES, default 16: bytes per configuration frame (frame = 8*FRAME_BYTES bits = 128).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset; synchronous, active-low.
REQ-004 start_wr  in  1  one-cycle request: load one frame into chain, then commit to state.
REQ-005 start_rd  in  1  one-cycle request: copy state to chain, then read it out nondestructively.
REQ-006 in_data  in  8  write byte; in_valid in 1; in_ready out 1  valid/ready handshake, byte taken when both high.
REQ-007 rd_data  out  8  readback byte; rd_valid out 1; rd_ready in 1  valid/ready handshake.
REQ-008 chain_msb  in  1  chain bit 127 (registered uo_out[7] of the chain block).
REQ-009 chain_datum, chain_shift, chain_transfer, chain_dir, chain_stateen  out  1 each  drive chain ui_in[0..4].
REQ-010 busy  out  1  high outside IDLE; done  out  1  one-cycle completion pulse.

Function
REQ-011 States: IDLE, WR_FETCH, WR_HI, WR_LO, WR_COMMIT, RD_XFER, RD_LO, RD_HI, RD_WAIT, DONE.
REQ-012 IDLE: start_wr -> WR_FETCH; else start_rd -> RD_XFER; both high -> write wins; starts ignored when not IDLE.
REQ-013 in_ready high only in WR_FETCH; stays in WR_FETCH with all chain strobes low until byte accepted, then -> WR_HI.
REQ-014 Each bit: WR_HI (chain_shift=1) one cycle, then WR_LO (chain_shift=0) one cycle; chain_datum stable over both.
REQ-015 Bit order: byte j bit i is shifted as frame bit k=8j+i, byte 0 first, LSB first; after 128 shifts frame bit k sits at chain[127-k].
REQ-016 After bit 7 of a byte: next byte -> WR_FETCH; after last byte -> WR_COMMIT (chain_transfer=1, chain_dir=1, one cycle) -> DONE.
REQ-017 Unstalled write: FRAME_BYTES*17 + 1 cycles from leaving IDLE to DONE (273 for 16).
REQ-018 RD_XFER: chain_transfer=1, chain_dir=0 one cycle -> RD_LO.
REQ-019 RD_LO: register chain_msb into bit reg and deserializer; RD_HI: chain_shift=1, chain_datum=bit reg (rotate; chain restored after 128 bits).
REQ-020 Captured bit n (n=0 first) is rd byte n/8 bit n%8, so readback bytes equal written bytes.
REQ-021 When 8 bits gathered: load rd_data, raise rd_valid if rd_valid low or handshake completes that cycle; otherwise RD_WAIT (strobes low) until free.
REQ-022 rd_valid held with rd_data stable until rd_ready; last byte accepted -> DONE.
REQ-023 DONE: done=1 one cycle -> IDLE; busy low in IDLE only.
REQ-024 chain_transfer and chain_shift never high in the same cycle; chain_dir low except in WR_COMMIT.
REQ-025 chain_stateen=1 whenever rst_n was high at previous edge.
REQ-026 Bit and byte counters wrap modulo 8 and FRAME_BYTES; no partial frames; no abort except reset.

Reset
REQ-027 rst_n low at an edge: state IDLE, counters 0, all outputs 0 (incl. chain_stateen, rd_data, rd_valid), regardless of operation in progress.
REQ-028 Reset mid-frame discards the partial frame; chain state register untouched by this block since no transfer issued.

Structure
REQ-029 pudding_pkg holds FRAME_BITS=128, FRAME_BYTES=16, state enum type, strobe bit positions in ui_in.
REQ-030 One sub-module natural: pudding_byte_sr (8-bit load/shift-out, shift-in/parallel-out, bit counter).

Verification
REQ-031 Bench instantiates loader driving heichips25_pudding; reference model of chain/state compared every cycle.
REQ-032 Write bytes 0x10,0x32,0x54,0x76,0x98,0xba,0xdc,0xfe,0xef,0xcd,0xab,0x89,0x67,0x45,0x23,0x01 -> done at cycle 273, uio_out=0x08, uo_out=0x08.
REQ-033 Read after REQ-032 with rd_ready=1 -> same 16 bytes in order, uo_out=0x08 after done.
REQ-034 Write with in_valid low 5 cycles before byte 3 -> strobes low during stall, same final state, done at cycle 278.
REQ-035 Read with rd_ready low 20 cycles on byte 0 -> RD_WAIT entered, no extra shifts, bytes intact.
REQ-036 rst_n low at bit 60 of a write, then start_rd -> readback returns previous committed frame.
